if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined CPU; the producer side of the IF/ID interface that id_stage consumes.
- Holds the PC and drives the instruction-memory address.
- Latches the fetched word and PC+4 into the IF/ID register, together with the debug tags IF_ins_type and IF_ins_number.
- Obeys the ID-stage stall signal cu_wpcir and the branch/jump redirect cu_branch/branch_pc.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INST, 32'h0000_0000, bubble word inserted on flush/boot.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cu_wpcir  in  1  from ID: 1 = PC and IF/ID may update; 0 = hold both (stall).
- cu_branch  in  1  from ID: taken branch/jump resolved this cycle.
- branch_pc  in  32  redirect target, valid when cu_branch=1.
- imem_addr  out  32  combinational copy of the PC, to instruction memory.
- imem_data  in  32  instruction word at imem_addr (asynchronous read).
- pc  out  32  current PC (debug).
- if_inst  out  32  IF/ID instruction register.
- if_pc4  out  32  IF/ID PC+4 register.
- IF_ins_type  out  4  class tag of if_inst.
- IF_ins_number  out  4  fetch sequence tag of if_inst.

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, if_inst=NOP_INST, if_pc4=0, IF_ins_type=0, IF_ins_number=0, seq counter=0, state=BOOT.
- FSM, two states:
  - BOOT: PC held and IF/ID held at bubble for one clock; then go to RUN unconditionally; cu_wpcir and cu_branch are ignored.
  - RUN: normal operation; stays in RUN until reset.
- RUN, rising edge, priority high to low:
  - cu_wpcir=0: pc, IF/ID and seq counter all hold; cu_branch is ignored (operands not ready).
  - cu_wpcir=1 and cu_branch=1: pc <= branch_pc; IF/ID loads NOP_INST, if_pc4=0, type=0, number=0 (flush; no delay slot); seq counter holds.
  - cu_wpcir=1 and cu_branch=0: pc <= pc+4; if_inst <= imem_data; if_pc4 <= pc+4; type per the class rule; number <= next seq.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
- branch_pc is used as-is, with no alignment check.
- Seq counter runs 1..15 and wraps 15 -> 1; 0 is reserved for bubbles.
- Class rule on imem_data[31:26] (whole word for NOP):
  - word == 0 -> 0 (nop)
  - op 0x00 -> 1 (R-type)
  - op 0x08..0x0F -> 2 (I-ALU)
  - op 0x23 -> 3 (load)
  - op 0x2B -> 4 (store)
  - op 0x04/0x05 -> 5 (branch)
  - op 0x02/0x03 -> 6 (jump)
  - anything else -> 15 (unknown)
- Latency: the word at PC appears on if_inst one clock after the PC is presented.
- Reset asserted mid-stall or mid-redirect: all state returns to its reset value immediately; BOOT repeats after release.

Decomposition:
- Shared package/header holds the opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, I-ALU range) and the class codes 0..6 and 15.
- Id_stage reuses these constants.
- One combinational sub-module, inst_classify (32-bit word in, 4-bit class out), shared with later stages' debug tagging.

Test Plan:
- Reset release, imem returns 32'h8c090014 at addr 0 -> first edge: bubble with pc=0 (BOOT); second edge: if_inst=8c090014, if_pc4=4, type=3, number=1, pc=4.
- Sequential fetch 00a64004, 01074806, 0c000011, 27eb0008 -> types 1, 1, 6, 2; numbers 2, 3, 4, 5; if_pc4 = 8, C, 10, 14.
- cu_wpcir=0 for 2 cycles with cu_branch=1 and branch_pc=0x40 -> pc, if_inst and number unchanged; the redirect is ignored.
- cu_wpcir=1, cu_branch=1, branch_pc=0x44 -> pc=0x44; if_inst=0, type=0, number=0; the next fetch takes number = previous+1.
- 16 consecutive fetches -> number sequence goes ...14, 15, 1, 2 and never shows 0 on a real fetch.
- Drive pc to 0xFFFFFFFC via branch, then fetch -> if_pc4=0, pc=0.
- Assert rst mid-stall -> all outputs are at reset values asynchronously, and one BOOT cycle follows release.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared opcode constants, instruction class codes and fetch-stage types.
// Later pipeline stages import this package for decode and debug tagging.
package if_stage_pkg;

    localparam logic [5:0] OP_RTYPE   = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_IALU_LO = 6'h08;
    localparam logic [5:0] OP_IALU_HI = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [3:0] CLS_NOP     = 4'd0;
    localparam logic [3:0] CLS_RTYPE   = 4'd1;
    localparam logic [3:0] CLS_IALU    = 4'd2;
    localparam logic [3:0] CLS_LOAD    = 4'd3;
    localparam logic [3:0] CLS_STORE   = 4'd4;
    localparam logic [3:0] CLS_BRANCH  = 4'd5;
    localparam logic [3:0] CLS_JUMP    = 4'd6;
    localparam logic [3:0] CLS_UNKNOWN = 4'd15;

    typedef enum logic {StBoot, StRun} if_state_e;

    // Fetch sequence tag runs 1..15; 0 is kept for bubbles.
    function automatic logic [3:0] seq_next(input logic [3:0] seq);
        return (seq == 4'd15) ? 4'd1 : seq + 4'd1;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// IF-stage bundle: ID control inputs, instruction memory port and IF/ID register outputs.
interface if_stage_if;
    logic        cu_wpcir;
    logic        cu_branch;
    logic [31:0] branch_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pc;
    logic [31:0] if_inst;
    logic [31:0] if_pc4;
    logic [3:0]  IF_ins_type;
    logic [3:0]  IF_ins_number;

    modport master (
        input  cu_wpcir, cu_branch, branch_pc, imem_data,
        output imem_addr, pc, if_inst, if_pc4, IF_ins_type, IF_ins_number
    );

    modport slave (
        output cu_wpcir, cu_branch, branch_pc, imem_data,
        input  imem_addr, pc, if_inst, if_pc4, IF_ins_type, IF_ins_number
    );
endinterface

// File: rtl/inst_classify.sv
// Maps a 32-bit instruction word to its 4-bit debug class code.
module inst_classify
    import if_stage_pkg::*;
(
    input  logic [31:0] inst_i,
    output logic [3:0]  ins_class_o
);
    logic [5:0] op;

    always_comb begin
        op          = inst_i[31:26];
        ins_class_o = CLS_UNKNOWN;
        if (inst_i == 32'h0)                             ins_class_o = CLS_NOP;
        else if (op == OP_RTYPE)                         ins_class_o = CLS_RTYPE;
        else if (op >= OP_IALU_LO && op <= OP_IALU_HI)   ins_class_o = CLS_IALU;
        else if (op == OP_LW)                            ins_class_o = CLS_LOAD;
        else if (op == OP_SW)                            ins_class_o = CLS_STORE;
        else if (op == OP_BEQ || op == OP_BNE)           ins_class_o = CLS_BRANCH;
        else if (op == OP_J || op == OP_JAL)             ins_class_o = CLS_JUMP;
    end
endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, imem address and the IF/ID pipeline register.
// One BOOT cycle after reset, then fetch, stall or flush-and-redirect each clock.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input logic        clk,
    input logic        rst,
    if_stage_if.master bus
);
    if_state_e   state_q, state_d;
    logic [31:0] pc_q, inst_q, pc4_q;
    logic [3:0]  type_q, num_q, seq_q;
    logic [31:0] pc_plus4;
    logic [3:0]  fetch_class;
    logic        fetch_en, flush;

    inst_classify u_classify (
        .inst_i      (bus.imem_data),
        .ins_class_o (fetch_class)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= StBoot;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StBoot:  state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StBoot;
        endcase
    end

    // Stall outranks redirect: a branch seen while stalled is not acted on.
    always_comb begin
        fetch_en = 1'b0;
        flush    = 1'b0;
        if (state_q == StRun && bus.cu_wpcir) begin
            flush    = bus.cu_branch;
            fetch_en = !bus.cu_branch;
        end
    end

    assign pc_plus4 = pc_q + 32'd4;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q   <= RESET_PC;
            inst_q <= NOP_INST;
            pc4_q  <= 32'h0;
            type_q <= CLS_NOP;
            num_q  <= 4'd0;
            seq_q  <= 4'd0;
        end else if (flush) begin
            pc_q   <= bus.branch_pc;
            inst_q <= NOP_INST;
            pc4_q  <= 32'h0;
            type_q <= CLS_NOP;
            num_q  <= 4'd0;
        end else if (fetch_en) begin
            pc_q   <= pc_plus4;
            inst_q <= bus.imem_data;
            pc4_q  <= pc_plus4;
            type_q <= fetch_class;
            num_q  <= seq_next(seq_q);
            seq_q  <= seq_next(seq_q);
        end
    end

    assign bus.imem_addr     = pc_q;
    assign bus.pc            = pc_q;
    assign bus.if_inst       = inst_q;
    assign bus.if_pc4        = pc4_q;
    assign bus.IF_ins_type   = type_q;
    assign bus.IF_ins_number = num_q;
endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: vector table plus hand-written multi-cycle sequences,
// with expected IF/ID contents queued at drive time and compared after each clock edge.
module tb_if_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;

    if_stage_if bus ();

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h00:  return 32'h8c090014;
            32'h04:  return 32'h00a64004;
            32'h08:  return 32'h01074806;
            32'h0C:  return 32'h0c000011;
            32'h10:  return 32'h27eb0008;
            32'h44:  return 32'hac220000;
            32'h48:  return 32'h10220003;
            32'h4C:  return 32'h00000000;
            32'h50:  return 32'hfc000000;
            default: return {6'h08, a[25:0]};
        endcase
    endfunction

    assign bus.imem_data = mem_rd(bus.imem_addr);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pc4;
        logic [3:0]  typ;
        logic [3:0]  num;
    } exp_t;

    typedef struct {
        logic        wpcir;
        logic        branch;
        logic [31:0] bpc;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_all(input string tag, input exp_t e);
        check({tag, " pc"},        bus.pc,            e.pc);
        check({tag, " imem_addr"}, bus.imem_addr,     e.pc);
        check({tag, " if_inst"},   bus.if_inst,       e.inst);
        check({tag, " if_pc4"},    bus.if_pc4,        e.pc4);
        check({tag, " type"},      {28'h0, bus.IF_ins_type},   {28'h0, e.typ});
        check({tag, " number"},    {28'h0, bus.IF_ins_number}, {28'h0, e.num});
    endtask

    task automatic step(input string tag, input logic w, input logic b, input logic [31:0] bpc,
                        input exp_t e);
        exp_t got_e;
        bus.cu_wpcir  = w;
        bus.cu_branch = b;
        bus.branch_pc = bpc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got_e = sb.pop_front();
        check_all(tag, got_e);
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] inst,
                                input logic [31:0] pc4, input logic [3:0] typ,
                                input logic [3:0] num);
        exp_t e;
        e.pc = pc; e.inst = inst; e.pc4 = pc4; e.typ = typ; e.num = num;
        return e;
    endfunction

    function automatic vec_t mv(input logic w, input logic b, input logic [31:0] bpc,
                                input exp_t e);
        vec_t v;
        v.wpcir = w; v.branch = b; v.bpc = bpc; v.e = e;
        return v;
    endfunction

    vec_t tbl[13];

    initial begin
        tbl[0]  = mv(1, 0, 32'h0,  mk(32'h00, 32'h00000000, 32'h00, 4'd0, 4'd0));
        tbl[1]  = mv(1, 0, 32'h0,  mk(32'h04, 32'h8c090014, 32'h04, 4'd3, 4'd1));
        tbl[2]  = mv(1, 0, 32'h0,  mk(32'h08, 32'h00a64004, 32'h08, 4'd1, 4'd2));
        tbl[3]  = mv(1, 0, 32'h0,  mk(32'h0C, 32'h01074806, 32'h0C, 4'd1, 4'd3));
        tbl[4]  = mv(1, 0, 32'h0,  mk(32'h10, 32'h0c000011, 32'h10, 4'd6, 4'd4));
        tbl[5]  = mv(1, 0, 32'h0,  mk(32'h14, 32'h27eb0008, 32'h14, 4'd2, 4'd5));
        tbl[6]  = mv(0, 1, 32'h40, mk(32'h14, 32'h27eb0008, 32'h14, 4'd2, 4'd5));
        tbl[7]  = mv(0, 1, 32'h40, mk(32'h14, 32'h27eb0008, 32'h14, 4'd2, 4'd5));
        tbl[8]  = mv(1, 1, 32'h44, mk(32'h44, 32'h00000000, 32'h00, 4'd0, 4'd0));
        tbl[9]  = mv(1, 0, 32'h0,  mk(32'h48, 32'hac220000, 32'h48, 4'd4, 4'd6));
        tbl[10] = mv(1, 0, 32'h0,  mk(32'h4C, 32'h10220003, 32'h4C, 4'd5, 4'd7));
        tbl[11] = mv(1, 0, 32'h0,  mk(32'h50, 32'h00000000, 32'h50, 4'd0, 4'd8));
        tbl[12] = mv(1, 0, 32'h0,  mk(32'h54, 32'hfc000000, 32'h54, 4'd15, 4'd9));

        bus.cu_wpcir  = 1'b1;
        bus.cu_branch = 1'b0;
        bus.branch_pc = 32'h0;
        #2;
        check_all("reset", mk(32'h0, 32'h0, 32'h0, 4'd0, 4'd0));
        #10;
        rst = 1'b1;

        for (int i = 0; i < 13; i++)
            step($sformatf("vec%0d", i), tbl[i].wpcir, tbl[i].branch, tbl[i].bpc, tbl[i].e);

        // Sixteen straight fetches cross the 15 -> 1 sequence wrap.
        for (int k = 1; k <= 16; k++) begin
            logic [31:0] a;
            logic [3:0]  n;
            a = 32'h54 + 32'(4 * (k - 1));
            n = 4'(((9 + k - 1) % 15) + 1);
            step($sformatf("seq%0d", k), 1'b1, 1'b0, 32'h0,
                 mk(a + 32'd4, {6'h08, a[25:0]}, a + 32'd4, 4'd2, n));
        end

        step("redir_top", 1'b1, 1'b1, 32'hFFFF_FFFC,
             mk(32'hFFFF_FFFC, 32'h0, 32'h0, 4'd0, 4'd0));
        step("pc_wrap", 1'b1, 1'b0, 32'h0, mk(32'h0, 32'h23FF_FFFC, 32'h0, 4'd2, 4'd11));
        step("after_wrap", 1'b1, 1'b0, 32'h0, mk(32'h4, 32'h8c090014, 32'h4, 4'd3, 4'd12));
        step("stall_pre_rst", 1'b0, 1'b1, 32'h80, mk(32'h4, 32'h8c090014, 32'h4, 4'd3, 4'd12));

        // Reset lands mid-cycle while stalled: outputs must clear without a clock edge.
        #3;
        rst = 1'b0;
        #1;
        check_all("async_rst", mk(32'h0, 32'h0, 32'h0, 4'd0, 4'd0));
        @(posedge clk);
        #1;
        check_all("rst_held", mk(32'h0, 32'h0, 32'h0, 4'd0, 4'd0));
        #2;
        rst = 1'b1;
        step("reboot", 1'b1, 1'b1, 32'h80, mk(32'h0, 32'h0, 32'h0, 4'd0, 4'd0));
        step("refetch", 1'b1, 1'b0, 32'h0, mk(32'h4, 32'h8c090014, 32'h4, 4'd3, 4'd1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
